// File: rtl/truth_table_checker_pkg.sv
// Shared types and helpers for the truth table checker.
package truth_chk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } chk_state_t;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between the checker and the circuits under test.
// Macro TRUTH_CHK_FAIL_MAP_EN adds the per-vector fail_map.
interface truth_table_checker_if #(
  parameter int N_IN = 3
);
  logic              start;
  logic              y_a;
  logic              y_b;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_fail_idx;
`ifdef TRUTH_CHK_FAIL_MAP_EN
  logic [(1<<N_IN)-1:0] fail_map;
`endif

  modport master (
    output start, y_a, y_b,
    input  stim, busy, done, pass, err_count, first_fail_idx
`ifdef TRUTH_CHK_FAIL_MAP_EN
    , input fail_map
`endif
  );

  modport slave (
    input  start, y_a, y_b,
    output stim, busy, done, pass, err_count, first_fail_idx
`ifdef TRUTH_CHK_FAIL_MAP_EN
    , output fail_map
`endif
  );
endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// Loadable down-counter; zero flags the end of the settle window.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into two implementations and scores them against TRUTH.
// Macro TRUTH_CHK_FAIL_MAP_EN adds the per-vector fail_map output.
//
// state  | meaning
// IDLE   | waiting for start
// APPLY  | drive stim with idx, load settle timer
// SETTLE | wait SETTLE_CYCLES clocks for outputs to settle
// CHECK  | compare y_a/y_b with TRUTH[idx], advance or finish
// DONE   | results valid, waiting for start
module truth_table_checker
  import truth_chk_pkg::*;
#(
  parameter int                     N_IN          = 3,
  parameter logic [(1<<N_IN)-1:0]   TRUTH         = 8'b1110_1000,
  parameter int                     SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave bus
);
  localparam int              NV       = vec_count(N_IN);
  localparam int              TW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_APPLY  = 3'(APPLY);
  localparam logic [2:0] ST_SETTLE = 3'(SETTLE);
  localparam logic [2:0] ST_CHECK  = 3'(CHECK);
  localparam logic [2:0] ST_DONE   = 3'(DONE);

  logic [2:0]      state;
  logic [N_IN-1:0] idx;
  logic [N_IN-1:0] stim_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] ffi_q;
  logic            tmr_zero;
  logic            exp_bit;
  logic            mismatch;
`ifdef TRUTH_CHK_FAIL_MAP_EN
  logic [NV-1:0]   fail_map_q;
`endif

  settle_timer #(.W(TW)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_APPLY),
    .load_val (SETTLE_LOAD),
    .dec      (state == ST_SETTLE),
    .zero     (tmr_zero)
  );

  // A vector counts once no matter how many implementations disagree.
  assign exp_bit  = TRUTH[idx];
  assign mismatch = (bus.y_a != exp_bit) | (bus.y_b != exp_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      stim_q <= '0;
      err_q  <= '0;
      ffi_q  <= '0;
`ifdef TRUTH_CHK_FAIL_MAP_EN
      fail_map_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state <= ST_APPLY;
            idx   <= '0;
            err_q <= '0;
            ffi_q <= '0;
`ifdef TRUTH_CHK_FAIL_MAP_EN
            fail_map_q <= '0;
`endif
          end
        end
        ST_APPLY: begin
          stim_q <= idx;
          state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_zero) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_q <= err_q + 1'b1;
            if (err_q == '0) ffi_q <= idx;
`ifdef TRUTH_CHK_FAIL_MAP_EN
            fail_map_q[idx] <= 1'b1;
`endif
          end
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign bus.done           = (state == ST_DONE);
  assign bus.pass           = (state == ST_DONE) && (err_q == '0);
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;
`ifdef TRUTH_CHK_FAIL_MAP_EN
  assign bus.fail_map       = fail_map_q;
`endif
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Synthesizable self-checking response analyzer for small combinational lab circuits. It sweeps all 2**N_IN input vectors, drives them to two DUT implementations of the same function (e.g. a NAND-only and a NOR-only realisation), waits a settle time, and compares both outputs against a golden truth table. It reports pass/fail, a mismatch count and the first failing vector. It closes the loop so that a minimised design can be checked on hardware without a simulator waveform.

Parameters:
N_IN, 3, number of DUT inputs; vectors 0..2**N_IN-1
TRUTH, 8'b1110_1000, golden output for vector i at bit i; width 2**N_IN; default is 3-input majority
SETTLE_CYCLES, 2, clocks between driving a vector and sampling outputs; legal range >=1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
y_a  input  1  output of DUT implementation A
y_b  input  1  output of DUT implementation B
stim  output  N_IN  vector driven to both DUTs; MSB = first input (A)
busy  output  1  high from APPLY through CHECK of last vector
done  output  1  level, high in DONE until next start or rst
pass  output  1  done && err_count==0
err_count  output  N_IN+1  number of vectors where y_a or y_b != TRUTH[idx]
first_fail_idx  output  N_IN  index of first mismatching vector; 0 if none

Behaviour:
- Reset (rst=1 at an edge, any state incl. mid-sweep): state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, idx=0, settle counter=0.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: start=1 -> APPLY, idx=0, err_count=0, first_fail_idx=0.
- APPLY: stim<=idx, settle counter<=SETTLE_CYCLES-1 -> SETTLE.
- SETTLE: counter==0 -> CHECK, else decrement. Exactly SETTLE_CYCLES cycles in SETTLE.
- CHECK: exp=TRUTH[idx]; mismatch = (y_a!=exp)|(y_b!=exp); one vector counts once even if both DUTs fail. On mismatch err_count++; if err_count was 0, first_fail_idx<=idx. If idx==2**N_IN-1 -> DONE, else idx++ -> APPLY.
- stim holds constant from APPLY through CHECK of each vector; holds last vector in DONE.
- Timing: SETTLE_CYCLES+2 cycles per vector; done rises 2**N_IN*(SETTLE_CYCLES+2) edges after the edge that samples start (32 for defaults).
- DONE: done=1, pass valid. start=1 -> clears err_count/first_fail_idx/done, idx=0, -> APPLY.
- start while busy: ignored, no effect on sweep.
- err_count cannot overflow (max 2**N_IN fits N_IN+1 bits); idx never wraps within a sweep.
- y_a/y_b are sampled only in CHECK; X/changes elsewhere have no effect.

Optional Feature:
Macro TRUTH_CHK_FAIL_MAP_EN. Defined: extra output fail_map [2**N_IN-1:0], bit i set in CHECK when vector i mismatches; cleared by rst and on every accepted start. Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package truth_chk_pkg: state enum type chk_state_t (IDLE, APPLY, SETTLE, CHECK, DONE), helper function for vector count 2**N_IN.
- One sub-module natural: settle_timer (loadable down-counter, load value + zero flag), instantiated once.

Test Plan:
- Correct DUT models (y_a=y_b=majority(stim)), start pulse -> busy 1 for 32 cycles, done=1, pass=1, err_count=0, stim walks 0..7.
- y_b stuck at 0, y_a correct -> err_count=4, first_fail_idx=3, pass=0; with TRUTH_CHK_FAIL_MAP_EN fail_map=8'b1110_1000.
- Both y_a and y_b inverted -> err_count=8 (not 16), first_fail_idx=0.
- start re-asserted at cycle 10 of a sweep -> ignored; done still at cycle 32, results unchanged.
- rst asserted mid-sweep at idx=4 -> next cycle all outputs 0, state IDLE; new start gives full 32-cycle sweep.
- From DONE with err_count=4, start with correct DUT -> counters cleared on accept; finishes pass=1, err_count=0.
